// File: rtl/bram_program_loader.sv
// Streams a length/address header and little-endian program words from a byte link
// into the program BRAM, holding the core in reset until the image is complete.
module bram_program_loader #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_BITS     = 32,
  parameter int MEM_ADDRESS_BITS = 14
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      reload,
  output logic                      mem_write,
  output logic [DATA_WIDTH/8-1:0]   mem_byte_en,
  output logic [MEM_ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]     mem_data,
  output logic                      core_reset,
  output logic                      start,
  output logic [ADDRESS_BITS-1:0]   program_address,
  output logic                      busy,
  output logic                      error,
  output logic [1:0]                error_code
);

  typedef enum logic [2:0] {
    HDR_COUNT,
    HDR_ADDR,
    LOAD,
    START,
    RUN,
    ERROR
  } state_t;

  localparam logic [ADDRESS_BITS:0] CAPACITY = (ADDRESS_BITS+1)'(1) << MEM_ADDRESS_BITS;

  state_t                      state, next_state;
  logic [1:0]                  byte_cnt;
  logic [DATA_WIDTH-1:0]       shift;
  logic [DATA_WIDTH-1:0]       count;
  logic [DATA_WIDTH-1:0]       word_cnt;
  logic [MEM_ADDRESS_BITS-1:0] word_index;
  logic [1:0]                  code, next_code;
  logic                        accept, word_done, load_done;
  logic [DATA_WIDTH-1:0]       word;
  logic [ADDRESS_BITS:0]       end_word;

  // Bytes shift in from the top so the first byte lands in [7:0] after four transfers.
  assign word      = {in_data, shift[DATA_WIDTH-1:8]};
  assign load_done = (word_cnt == count);
  assign accept    = in_valid && in_ready;
  assign word_done = accept && (byte_cnt == 2'd3);
  assign end_word  = {3'b000, word[ADDRESS_BITS-1:2]} + {1'b0, count};

  // LOAD stops accepting once the final word is in; that cycle carries its write.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    if (!reset) begin
      unique case (state)
        HDR_COUNT, HDR_ADDR: begin
          in_ready = 1'b1;
          busy     = 1'b1;
        end
        LOAD: begin
          in_ready = !load_done;
          busy     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign start       = (state == START);
  assign error       = (state == ERROR);
  assign error_code  = code;
  assign mem_byte_en = mem_write ? '1 : '0;

  always_comb begin
    next_state = state;
    next_code  = code;
    unique case (state)
      HDR_COUNT: if (word_done) next_state = HDR_ADDR;
      HDR_ADDR: begin
        if (word_done) begin
          if (count == '0) begin
            next_state = ERROR;
            next_code  = 2'd1;
          end else if (word[1:0] != 2'b00) begin
            next_state = ERROR;
            next_code  = 2'd2;
          end else if (end_word > CAPACITY) begin
            next_state = ERROR;
            next_code  = 2'd3;
          end else begin
            next_state = LOAD;
          end
        end
      end
      LOAD:  if (load_done) next_state = START;
      START: next_state = RUN;
      RUN:   if (reload) next_state = HDR_COUNT;
      ERROR: begin
        if (reload) begin
          next_state = HDR_COUNT;
          next_code  = 2'd0;
        end
      end
      default: next_state = HDR_COUNT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= HDR_COUNT;
      code            <= 2'd0;
      byte_cnt        <= 2'd0;
      shift           <= '0;
      count           <= '0;
      word_cnt        <= '0;
      word_index      <= '0;
      program_address <= '0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_data        <= '0;
      core_reset      <= 1'b1;
    end else begin
      state      <= next_state;
      code       <= next_code;
      core_reset <= !(next_state == START || next_state == RUN);
      mem_write  <= 1'b0;
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        shift    <= word;
      end
      if (state == HDR_COUNT && word_done) count <= word;
      if (state == HDR_ADDR && word_done && next_state == LOAD) begin
        program_address <= word[ADDRESS_BITS-1:0];
        word_index      <= word[MEM_ADDRESS_BITS+1:2];
        word_cnt        <= '0;
      end
      if (state == LOAD && word_done) begin
        mem_write   <= 1'b1;
        mem_address <= word_index;
        mem_data    <= word;
        word_index  <= word_index + MEM_ADDRESS_BITS'(1);
        word_cnt    <= word_cnt + DATA_WIDTH'(1);
      end
      if (reload && (state == RUN || state == ERROR)) begin
        byte_cnt <= 2'd0;
        word_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bram_program_loader.sv
// Directed bench for bram_program_loader: expected BRAM writes are queued as programs
// are streamed in and popped by a monitor when the loader writes.
module tb_bram_program_loader;

  logic        clock;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        reload;
  logic        mem_write;
  logic [3:0]  mem_byte_en;
  logic [13:0] mem_address;
  logic [31:0] mem_data;
  logic        core_reset;
  logic        start;
  logic [31:0] program_address;
  logic        busy;
  logic        error;
  logic [1:0]  error_code;

  bram_program_loader #(
    .DATA_WIDTH(32),
    .ADDRESS_BITS(32),
    .MEM_ADDRESS_BITS(14)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .reload(reload),
    .mem_write(mem_write),
    .mem_byte_en(mem_byte_en),
    .mem_address(mem_address),
    .mem_data(mem_data),
    .core_reset(core_reset),
    .start(start),
    .program_address(program_address),
    .busy(busy),
    .error(error),
    .error_code(error_code)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_wr_cyc = -10;
  int          start_cnt = 0;
  logic [31:0] exp_pa = '0;
  logic [63:0] exp_wr;
  logic [63:0] sb[$];
  logic [31:0] prog[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (mem_write) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 64'(mem_write), 64'(0));
      end else begin
        exp_wr = sb.pop_front();
        check("wr_addr", 64'(mem_address), 64'(exp_wr[45:32]));
        check("wr_data", 64'(mem_data), 64'(exp_wr[31:0]));
        check("wr_byte_en", 64'(mem_byte_en), 64'(4'hF));
        check("wr_core_reset", 64'(core_reset), 64'(1));
      end
      last_wr_cyc = cyc;
    end
    if (start) begin
      start_cnt++;
      check("start_after_write", 64'(cyc), 64'(last_wr_cyc + 1));
      check("start_pa", 64'(program_address), 64'(exp_pa));
      check("start_core_reset", 64'(core_reset), 64'(0));
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 5)) begin @(posedge clock); #1; end
    end
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin @(posedge clock); #1; t++; end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clock); #1;
    reload = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // Streams header plus prog[0..n-1], queues the writes, and expects exactly one start.
  task automatic load_program(input logic [31:0] n, input logic [31:0] a, input bit gaps);
    int          s0;
    int          t;
    logic [13:0] wa;
    s0     = start_cnt;
    exp_pa = a;
    for (int i = 0; i < int'(n); i++) begin
      wa = a[15:2] + 14'(i);
      sb.push_back({18'b0, wa, prog[i]});
    end
    send_word(n, gaps);
    send_word(a, gaps);
    for (int i = 0; i < int'(n); i++) send_word(prog[i], gaps);
    t = 0;
    while (start_cnt == s0 && t < 50) begin @(posedge clock); #1; t++; end
    idle(3);
    check("start_once", 64'(start_cnt - s0), 64'(1));
    check("writes_drained", 64'(sb.size()), 64'(0));
    check("run_core_reset", 64'(core_reset), 64'(0));
    check("run_in_ready", 64'(in_ready), 64'(0));
    check("run_busy", 64'(busy), 64'(0));
    check("run_error", 64'(error), 64'(0));
  endtask

  task automatic bad_header(input logic [31:0] n, input logic [31:0] a, input logic [1:0] code);
    send_word(n, 1'b0);
    send_word(a, 1'b0);
    idle(3);
    check("err_flag", 64'(error), 64'(1));
    check("err_code", 64'(error_code), 64'(code));
    check("err_core_reset", 64'(core_reset), 64'(1));
    check("err_in_ready", 64'(in_ready), 64'(0));
    check("err_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    reload   = 1'b0;
    idle(3);
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_core_reset", 64'(core_reset), 64'(1));
    check("rst_mem_write", 64'(mem_write), 64'(0));
    check("rst_start", 64'(start), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    check("rst_error_code", 64'(error_code), 64'(0));
    check("rst_pa", 64'(program_address), 64'(0));
    reset = 1'b0;
    #1;
    check("hdr_in_ready", 64'(in_ready), 64'(1));
    check("hdr_busy", 64'(busy), 64'(1));

    // Nominal three-word image at address 0
    prog = '{32'h0000_0013, 32'h0010_0093, 32'h0000_006F};
    load_program(32'd3, 32'h0, 1'b0);

    // Bytes offered in RUN without reload must be ignored
    in_data  = 8'hAA;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check("run_ignore_in_ready", 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0;
    check("run_ignore_writes", 64'(sb.size()), 64'(0));

    pulse_reload();
    check("reload_core_reset", 64'(core_reset), 64'(1));
    check("reload_busy", 64'(busy), 64'(1));
    check("reload_pa_held", 64'(program_address), 64'(0));
    prog = '{32'hDEAD_BEEF, 32'h1234_5678, 32'h0BAD_F00D};
    load_program(32'd3, 32'h100, 1'b0);

    // Same nominal stream with random idle gaps between bytes
    pulse_reload();
    prog = '{32'h0000_0013, 32'h0010_0093, 32'h0000_006F};
    load_program(32'd3, 32'h0, 1'b1);

    // Capacity boundary: last four words fit, five overflow
    pulse_reload();
    prog = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    load_program(32'd4, 32'h0000_FFF0, 1'b0);
    pulse_reload();
    bad_header(32'd5, 32'h0000_FFF0, 2'd3);
    pulse_reload();
    check("err_clear_flag", 64'(error), 64'(0));
    check("err_clear_code", 64'(error_code), 64'(0));
    bad_header(32'd0, 32'h0, 2'd1);
    pulse_reload();
    bad_header(32'd1, 32'h2, 2'd2);
    idle(2);
    check("err_sticky_code", 64'(error_code), 64'(2));
    pulse_reload();
    prog = '{32'hCAFE_0001, 32'hCAFE_0002};
    load_program(32'd2, 32'h40, 1'b0);

    // Reset after two of three words: load abandoned, fresh header honoured
    pulse_reload();
    prog = '{32'hA5A5_0000, 32'hA5A5_0001, 32'hA5A5_0002};
    sb.push_back({18'b0, 14'd8, prog[0]});
    sb.push_back({18'b0, 14'd9, prog[1]});
    send_word(32'd3, 1'b0);
    send_word(32'h20, 1'b0);
    send_word(prog[0], 1'b0);
    send_word(prog[1], 1'b0);
    idle(1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(6);
    check("abort_writes", 64'(sb.size()), 64'(0));
    check("abort_core_reset", 64'(core_reset), 64'(1));
    check("abort_busy", 64'(busy), 64'(1));
    check("abort_pa", 64'(program_address), 64'(0));
    prog = '{32'h7777_0000, 32'h7777_0001};
    load_program(32'd2, 32'h80, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
